// File: rtl/bin_to_seg_digits_if.sv
// Request/result bundle for the binary-to-decimal digit generator.
// Driver side (master) supplies iSTART/iBIN; the converter (slave) returns
// busy/done/overflow status and the packed digit codes.
interface bin_to_seg_digits_if #(
    parameter int unsigned WIDTH  = 27,
    parameter int unsigned DIGITS = 8
);
    logic                  iSTART;
    logic [WIDTH-1:0]      iBIN;
    logic                  oBUSY;
    logic                  oDONE;
    logic                  oOVF;
    logic [5*DIGITS-1:0]   oDIG;

    modport master (
        output iSTART,
        output iBIN,
        input  oBUSY,
        input  oDONE,
        input  oOVF,
        input  oDIG
    );

    modport slave (
        input  iSTART,
        input  iBIN,
        output oBUSY,
        output oDONE,
        output oOVF,
        output oDIG
    );
endinterface

// File: rtl/bin_to_seg_digits.sv
// Sequential binary-to-decimal converter (shift-and-add-3, one bit per clock)
// producing one 5-bit display code per HEX position.
// Codes: 5'h00..5'h09 digit, 5'h0E overflow glyph, 5'h1F blank.
// Optional build macro SEG7_LZB_EN compiles in leading-zero blanking.
module bin_to_seg_digits #(
    parameter int unsigned WIDTH  = 27,
    parameter int unsigned DIGITS = 8
) (
    input  logic                  iCLK,
    input  logic                  iRST,
    bin_to_seg_digits_if.slave    bus
);

    localparam int unsigned BW = 4 * (DIGITS + 1);   // BCD nibbles plus guard
    localparam int unsigned DW = 5 * DIGITS;
    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q,   cnt_d;
    logic [WIDTH-1:0] bin_q,  bin_d;
    logic [BW-1:0]   bcd_q,   bcd_d;
    logic [BW-1:0]   bcd_adj;
    logic [DW-1:0]   dig_q,   dig_d;
    logic [DW-1:0]   dig_res;
    logic            ovf_q,   ovf_d;
    logic            ovf_res;
    logic            done_q,  done_d;
    logic            busy_q,  busy_d;

    // Add-3 correction on every nibble that would carry past 9 after doubling.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < int'(DIGITS) + 1; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    // Map the finished BCD accumulator to display codes (overflow glyph or digits).
    always_comb begin
`ifdef SEG7_LZB_EN
        logic lead;
        lead    = 1'b1;
`endif
        dig_res = '0;
        ovf_res = (bcd_q[BW-1 -: 4] != 4'd0);
        for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
            if (ovf_res) begin
                dig_res[5*i +: 5] = 5'h0E;
            end else begin
`ifdef SEG7_LZB_EN
                if (lead && (i != 0) && (bcd_q[4*i +: 4] == 4'd0)) begin
                    dig_res[5*i +: 5] = 5'h1F;
                end else begin
                    lead              = 1'b0;
                    dig_res[5*i +: 5] = {1'b0, bcd_q[4*i +: 4]};
                end
`else
                dig_res[5*i +: 5] = {1'b0, bcd_q[4*i +: 4]};
`endif
            end
        end
    end

    // Next-state and datapath updates for IDLE -> SHIFT x WIDTH -> DONE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        dig_d   = dig_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;
        busy_d  = busy_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.iSTART) begin
                    bin_d   = bus.iBIN;
                    bcd_d   = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                bcd_d = (bcd_adj << 1) | BW'(bin_q[WIDTH-1]);
                bin_d = bin_q << 1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_DONE: begin
                dig_d   = dig_res;
                ovf_d   = ovf_res;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset blanks the display.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bin_q   <= '0;
            bcd_q   <= '0;
            dig_q   <= {DIGITS{5'h1F}};
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            dig_q   <= dig_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.oBUSY = busy_q;
    assign bus.oDONE = done_q;
    assign bus.oOVF  = ovf_q;
    assign bus.oDIG  = dig_q;

endmodule

// File: tb/tb_bin_to_seg_digits.sv
// Self-checking bench for bin_to_seg_digits: directed table, randomized values
// against a decimal-arithmetic model, and multi-cycle handshake/reset sequences.
module tb_bin_to_seg_digits;

    localparam int unsigned WIDTH  = 27;
    localparam int unsigned DIGITS = 8;
    localparam int unsigned DW     = 5 * DIGITS;
    localparam int unsigned LAT    = WIDTH + 1;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    bin_to_seg_digits_if #(.WIDTH(WIDTH), .DIGITS(DIGITS)) bus ();

    bin_to_seg_digits #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
        .iCLK (clk),
        .iRST (rst),
        .bus  (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [WIDTH-1:0] bin;
        logic [DW-1:0]    dig;
        logic             ovf;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain decimal arithmetic on the value, then display rules.
    function automatic logic [DW-1:0] model(input longint unsigned v, output logic ovf);
        longint unsigned lim;
        int              d[DIGITS];
        logic [DW-1:0]   r;
        bit              lead;
        lim = 1;
        for (int i = 0; i < int'(DIGITS); i++) lim = lim * 10;
        ovf = (v >= lim);
        r   = '0;
        if (ovf) begin
            for (int i = 0; i < int'(DIGITS); i++) r[5*i +: 5] = 5'h0E;
            return r;
        end
        for (int i = 0; i < int'(DIGITS); i++) begin
            d[i] = int'(v % 10);
            v    = v / 10;
        end
        lead = 1'b1;
        for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
`ifdef SEG7_LZB_EN
            if (lead && i > 0 && d[i] == 0) begin
                r[5*i +: 5] = 5'h1F;
            end else begin
                lead        = 1'b0;
                r[5*i +: 5] = 5'(d[i]);
            end
`else
            r[5*i +: 5] = 5'(d[i]);
`endif
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One pulse-started conversion; checks busy, latency, hold and done pulse width.
    task automatic convert(input logic [WIDTH-1:0] v, input string tag,
                           output logic [DW-1:0] dig, output logic ovf);
        logic [DW-1:0] prev_dig;
        logic          prev_ovf;
        int            n;
        bit            held;
        prev_dig   = bus.oDIG;
        prev_ovf   = bus.oOVF;
        bus.iBIN   = v;
        bus.iSTART = 1'b1;
        tick();
        bus.iSTART = 1'b0;
        bus.iBIN   = WIDTH'($urandom);
        check({tag, "_busy_after_accept"}, 64'(bus.oBUSY), 64'd1);
        held = 1'b1;
        n    = 0;
        while (n < 40) begin
            tick();
            n++;
            if (bus.oDONE) break;
            if (bus.oDIG !== prev_dig || bus.oOVF !== prev_ovf) held = 1'b0;
        end
        check({tag, "_latency"}, 64'(n), 64'(LAT));
        check({tag, "_hold"}, 64'(held), 64'd1);
        check({tag, "_busy_at_done"}, 64'(bus.oBUSY), 64'd0);
        dig = bus.oDIG;
        ovf = bus.oOVF;
        tick();
        check({tag, "_done_fall"}, 64'(bus.oDONE), 64'd0);
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        logic [DW-1:0] dig, exp_dig;
        logic          ovf, exp_ovf;
        logic [WIDTH-1:0] v;
        int            done_edges[$];
        logic [DW-1:0] dig28, dig56, dig57;
        logic          busy29, done29;
        bit            seen;

        // Directed vectors; decimal expectations written out by hand.
`ifdef SEG7_LZB_EN
        vecs[0] = '{bin: 27'd0,     dig: {{7{5'h1F}}, 5'h00}, ovf: 1'b0};
        vecs[1] = '{bin: 27'd12345, dig: {{3{5'h1F}}, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5}, ovf: 1'b0};
        vecs[6] = '{bin: 27'd7,     dig: {{7{5'h1F}}, 5'd7}, ovf: 1'b0};
`else
        vecs[0] = '{bin: 27'd0,     dig: {8{5'h00}}, ovf: 1'b0};
        vecs[1] = '{bin: 27'd12345, dig: {{3{5'h00}}, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5}, ovf: 1'b0};
        vecs[6] = '{bin: 27'd7,     dig: {{7{5'h00}}, 5'd7}, ovf: 1'b0};
`endif
        vecs[2] = '{bin: 27'd99999999,  dig: {8{5'd9}},  ovf: 1'b0};
        vecs[3] = '{bin: 27'd100000000, dig: {8{5'h0E}}, ovf: 1'b1};
        vecs[4] = '{bin: 27'd134217727, dig: {8{5'h0E}}, ovf: 1'b1};
        vecs[5] = '{bin: 27'd10000000,  dig: {5'd1, {7{5'd0}}}, ovf: 1'b0};

        rst        = 1'b1;
        bus.iSTART = 1'b0;
        bus.iBIN   = '0;
        tick();
        tick();
        check("reset_dig",  64'(bus.oDIG),  64'({DIGITS{5'h1F}}));
        check("reset_busy", 64'(bus.oBUSY), 64'd0);
        check("reset_done", 64'(bus.oDONE), 64'd0);
        check("reset_ovf",  64'(bus.oOVF),  64'd0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 7; i++) begin
            convert(vecs[i].bin, $sformatf("vec%0d", i), dig, ovf);
            check($sformatf("vec%0d_dig", i), 64'(dig), 64'(vecs[i].dig));
            check($sformatf("vec%0d_ovf", i), 64'(ovf), 64'(vecs[i].ovf));
        end

        // Randomized values across full range, small values and the overflow boundary.
        for (int i = 0; i < 24; i++) begin
            case ($urandom_range(0, 2))
                0:       v = WIDTH'($urandom);
                1:       v = WIDTH'($urandom_range(0, 999));
                default: v = WIDTH'(99999990 + $urandom_range(0, 20));
            endcase
            convert(v, $sformatf("rnd%0d", i), dig, ovf);
            exp_dig = model(longint'(v), exp_ovf);
            check($sformatf("rnd%0d_dig(v=%0d)", i, v), 64'(dig), 64'(exp_dig));
            check($sformatf("rnd%0d_ovf(v=%0d)", i, v), 64'(ovf), 64'(exp_ovf));
        end

        // iSTART held high: 7 accepted at E0, iBIN changes to 8 after E5, next accept at E29.
        bus.iBIN   = 27'd7;
        bus.iSTART = 1'b1;
        dig28 = '0; dig56 = '0; dig57 = '0; busy29 = 1'b0; done29 = 1'b1;
        for (int k = 0; k <= 60; k++) begin
            tick();
            if (k == 5) bus.iBIN = 27'd8;
            if (bus.oDONE) done_edges.push_back(k);
            if (k == 28) dig28 = bus.oDIG;
            if (k == 29) begin busy29 = bus.oBUSY; done29 = bus.oDONE; end
            if (k == 56) dig56 = bus.oDIG;
            if (k == 57) dig57 = bus.oDIG;
        end
        bus.iSTART = 1'b0;
        check("b2b_done_count", 64'(done_edges.size()), 64'd2);
        if (done_edges.size() >= 2) begin
            check("b2b_first_done_edge",  64'(done_edges[0]), 64'(LAT));
            check("b2b_second_done_edge", 64'(done_edges[1]), 64'(2 * LAT + 1));
        end
        exp_dig = model(64'd7, exp_ovf);
        check("b2b_first_result",  64'(dig28), 64'(exp_dig));
        check("b2b_hold_until_second", 64'(dig56), 64'(exp_dig));
        check("b2b_busy_e29", 64'(busy29), 64'd1);
        check("b2b_done_e29", 64'(done29), 64'd0);
        exp_dig = model(64'd8, exp_ovf);
        check("b2b_second_result", 64'(dig57), 64'(exp_dig));
        // Let the third (auto-accepted) conversion drain.
        seen = 1'b0;
        for (int k = 0; k < 60; k++) begin
            tick();
            if (!bus.oBUSY && !bus.oDONE) begin seen = 1'b1; break; end
        end
        check("b2b_drain_idle", 64'(seen), 64'd1);

        // iSTART asserted exactly on the DONE cycle must be ignored.
        bus.iBIN   = 27'd5;
        bus.iSTART = 1'b1;
        tick();
        bus.iSTART = 1'b0;
        repeat (WIDTH) tick();
        check("donecyc_busy_before", 64'(bus.oBUSY), 64'd1);
        check("donecyc_done_before", 64'(bus.oDONE), 64'd0);
        bus.iSTART = 1'b1;
        tick();
        bus.iSTART = 1'b0;
        check("donecyc_done_pulse", 64'(bus.oDONE), 64'd1);
        exp_dig = model(64'd5, exp_ovf);
        check("donecyc_result", 64'(bus.oDIG), 64'(exp_dig));
        seen = 1'b0;
        repeat (6) begin
            tick();
            if (bus.oBUSY) seen = 1'b1;
        end
        check("donecyc_start_ignored", 64'(seen), 64'd0);

        // Reset for two cycles mid-conversion aborts with no later done pulse.
        bus.iBIN   = 27'd12345;
        bus.iSTART = 1'b1;
        tick();
        bus.iSTART = 1'b0;
        repeat (10) tick();
        rst = 1'b1;
        tick();
        tick();
        check("midrst_dig",  64'(bus.oDIG),  64'({DIGITS{5'h1F}}));
        check("midrst_busy", 64'(bus.oBUSY), 64'd0);
        check("midrst_ovf",  64'(bus.oOVF),  64'd0);
        check("midrst_done", 64'(bus.oDONE), 64'd0);
        rst  = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            tick();
            if (bus.oDONE || bus.oBUSY) seen = 1'b1;
        end
        check("midrst_no_done", 64'(seen), 64'd0);

        // Reset wins over a simultaneous start request.
        rst        = 1'b1;
        bus.iSTART = 1'b1;
        tick();
        rst        = 1'b0;
        bus.iSTART = 1'b0;
        check("rst_priority_busy", 64'(bus.oBUSY), 64'd0);
        tick();
        check("rst_priority_busy_after", 64'(bus.oBUSY), 64'd0);

        // Normal operation resumes after reset.
        convert(vecs[1].bin, "post_rst", dig, ovf);
        check("post_rst_dig", 64'(dig), 64'(vecs[1].dig));
        check("post_rst_ovf", 64'(ovf), 64'(vecs[1].ovf));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bin_to_seg_digits.md
# bin_to_seg_digits

Sequential binary-to-decimal digit generator for the 7-segment display path. Converts an unsigned binary value to DIGITS decimal digits with a shift-and-add-3 (double-dabble) engine, one input bit per clock. Emits one 5-bit digit code per display position, ready to drive one SEG7_LUT instance per HEX display. Codes 5'h00–5'h09 are decimal digits, 5'h0E is the overflow glyph and 5'h1F is blank.

## Interface
Parameters:
- WIDTH, 27: binary input width; conversion takes WIDTH shift cycles.
- DIGITS, 8: number of decimal output digits (one per HEX display).

Ports:
- iCLK  in  1  clock; all state changes on the rising edge.
- iRST  in  1  reset; synchronous, active-high.
- iSTART  in  1  request conversion of iBIN; sampled only in IDLE.
- iBIN  in  WIDTH  unsigned value; captured on the accepting edge only.
- oBUSY  out  1  registered; high while a conversion is in flight.
- oDONE  out  1  registered; one-cycle pulse when oDIG/oOVF update.
- oOVF  out  1  registered; high when the last value exceeded 10^DIGITS−1.
- oDIG  out  5*DIGITS  digit codes; oDIG[5i+4:5i] is digit i, digit 0 least significant (HEX0).

Clock and reset: one clock, iCLK; reset iRST is synchronous and active-high.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE: iSTART=1 → load shift register with iBIN, clear BCD accumulator (DIGITS+1 nibbles, one guard nibble), clear bit counter, go to SHIFT. iSTART=0 → stay.
- SHIFT: each cycle add 3 to every BCD nibble ≥5, then shift {BCD, bin} left one bit. Counter counts 0..WIDTH−1; at the edge performing shift WIDTH−1, go to DONE.
- DONE: for one edge, compute the result and register it into oDIG/oOVF, pulse oDONE, go to IDLE.
- Overflow: guard nibble ≠ 0 → oOVF=1, every digit = 5'h0E. Otherwise oOVF=0, digits = BCD nibbles zero-extended to 5 bits, with leading-zero blanking applied (see Configuration).
- oDIG/oOVF hold their previous value for the whole conversion; the display must not flicker.
- iSTART while oBUSY=1 is ignored and is not queued. Changes on iBIN after acceptance are ignored.
- Nibble arithmetic is 4-bit. Add-3 is applied before the shift within the same cycle, and a corrected nibble never exceeds 4'hC.

## Timing
- Accepting edge E0 (IDLE, iSTART=1): oBUSY=1 after E0.
- Shifts occur on E1..E(WIDTH); state is DONE after E(WIDTH).
- At E(WIDTH+1): oDIG/oOVF updated, oDONE=1, oBUSY=0, state IDLE. oDONE falls at E(WIDTH+2).
- Latency is WIDTH+1 edges from acceptance to valid output. The earliest next accept is E(WIDTH+2), giving a back-to-back period of WIDTH+2 cycles (29 at default).
- iSTART high at E(WIDTH+1) (state DONE) is ignored.
- Reset values: oDIG all 5'h1F (blank), oBUSY=0, oDONE=0, oOVF=0, state IDLE, counter 0.
- iRST mid-conversion aborts the conversion and applies reset values on that edge; no oDONE is produced. iRST has priority over iSTART on the same edge.

## Configuration
- SEG7_LZB_EN defined: leading-zero blanking is compiled in. Starting from digit DIGITS−1 downward, zero digits are replaced by 5'h1F until the first nonzero digit. Digit 0 is never blanked, so value 0 shows as a single "0". Blanking does not apply on overflow.
- SEG7_LZB_EN undefined: all DIGITS digits are shown, including leading zeros.
- Reset output is all-blank in both builds.

## Test plan
- Reset: assert iRST 2 cycles mid-conversion → oDIG = all 5'h1F, oBUSY=0, oOVF=0, and no oDONE pulse afterward.
- iBIN=0, iSTART pulse → oDONE exactly 28 edges after acceptance. With SEG7_LZB_EN, oDIG = seven 5'h1F then 5'h00 in digit 0. Without it, all eight digits are 5'h00.
- iBIN=12345 → with SEG7_LZB_EN, digits 7..0 = 1F,1F,1F,01,02,03,04,05. Without it, digits 7..0 = 00,00,00,01,02,03,04,05.
- iBIN=99999999 → digits 7..0 all 5'h09, oOVF=0. Then iBIN=100000000 → all digits 5'h0E, oOVF=1.
- iSTART held high continuously with iBIN=7, changed to 8 at E5 → first result is 7, and the second accept occurs at E29. oDIG holds 7 until the second oDONE, then shows 8.
- iSTART pulse on the DONE cycle → ignored, and oBUSY stays 0 afterwards.
